reg_jogador_selecao: RTL

//  Parametrised player-selection register for the game datapath. Turns N one-hot

---
 rtl/reg_jogador_selecao_if.sv | 33 +++
 rtl/reg_jogador_selecao.sv | 184 ++++++++++++++++++
 2 files changed

// File: rtl/reg_jogador_selecao_if.sv
// Player-selection bus: buttons, alive mask, confirm/cancel, the committed-index
// handshake and the error/timeout pulses, grouped between the game control unit
// (master) and the selection register (slave).
interface reg_jogador_selecao_if #(
    parameter int N_JOGADORES = 5,
    parameter int W_IDX       = 3
);
    logic                   habilita;
    logic [N_JOGADORES-1:0] botoes_jogadores;
    logic [N_JOGADORES-1:0] vivos;
    logic                   botao_confirma;
    logic                   botao_cancela;
    logic                   ack;
    logic [W_IDX-1:0]       jogador_escolhido;
    logic                   jogador_valido;
    logic [W_IDX-1:0]       jogador_pendente;
    logic                   pendente;
    logic                   erro_multiplo;
    logic                   erro_eliminado;
    logic                   expirou;

    modport master (
        output habilita, botoes_jogadores, vivos, botao_confirma, botao_cancela, ack,
        input  jogador_escolhido, jogador_valido, jogador_pendente, pendente,
               erro_multiplo, erro_eliminado, expirou
    );

    modport slave (
        input  habilita, botoes_jogadores, vivos, botao_confirma, botao_cancela, ack,
        output jogador_escolhido, jogador_valido, jogador_pendente, pendente,
               erro_multiplo, erro_eliminado, expirou
    );
endinterface

// File: rtl/reg_jogador_selecao.sv
// Player-selection register: turns one-hot player buttons into a registered
// player index, with edge detection, rejection of ambiguous or dead-player
// presses, an optional pending/confirm stage with timeout, and a valid/ack
// handshake towards the game control unit.
module reg_jogador_selecao #(
    parameter int N_JOGADORES    = 5,
    parameter int W_IDX          = 3,
    parameter bit MODO_CONFIRMA  = 1'b1,
    parameter int TIMEOUT_CICLOS = 0
) (
    input  logic                  clock,
    input  logic                  reset,
    reg_jogador_selecao_if.slave  bus
);
    localparam int W_CNT = (TIMEOUT_CICLOS > 1) ? $clog2(TIMEOUT_CICLOS) : 1;
    localparam logic [W_CNT-1:0] CNT_MAX =
        (TIMEOUT_CICLOS > 0) ? W_CNT'(TIMEOUT_CICLOS - 1) : '0;

    typedef enum logic [1:0] {
        OCIOSO   = 2'd0,
        AGUARDA  = 2'd1,
        PENDENTE = 2'd2,
        VALIDO   = 2'd3
    } estado_t;

    estado_t                state_reg;
    logic [N_JOGADORES-1:0] botoes_q_reg;
    logic                   confirma_q_reg;
    logic                   cancela_q_reg;
    logic [N_JOGADORES-1:0] pend_oh_reg;
    logic [W_CNT-1:0]       cnt_reg;
    logic [W_IDX-1:0]       escolhido_reg;
    logic                   valido_reg;
    logic [W_IDX-1:0]       pend_idx_reg;
    logic                   pendente_reg;
    logic                   erro_multiplo_reg;
    logic                   erro_eliminado_reg;
    logic                   expirou_reg;

    logic [N_JOGADORES-1:0] press;
    logic                   press_unico;
    logic                   press_multi;
    logic                   press_vivo;
    logic                   pend_vivo;
    logic                   confirma_ev;
    logic                   cancela_ev;
    logic [W_IDX-1:0]       press_idx;

    // A press is a rising edge; it is only usable when it is the one and only
    // button high, otherwise it is reported as ambiguous.
    assign press       = bus.botoes_jogadores & ~botoes_q_reg;
    assign press_unico = $onehot(press) && (bus.botoes_jogadores == press);
    assign press_multi = (press != '0) && !press_unico;
    assign press_vivo  = |(press & bus.vivos);
    assign pend_vivo   = |(pend_oh_reg & bus.vivos);
    assign confirma_ev = bus.botao_confirma & ~confirma_q_reg;
    assign cancela_ev  = bus.botao_cancela & ~cancela_q_reg;

    // Encode the single pressed button into its player index.
    always_comb begin
        press_idx = '0;
        for (int i = 0; i < N_JOGADORES; i++) begin
            if (press[i]) begin
                press_idx = W_IDX'(i);
            end
        end
    end

    // Selection FSM with edge registers, timeout counter and registered outputs.
    // In PENDENTE the order is: window closed, pending player died, cancel,
    // confirm, new press (restarts the timer), then timeout.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_reg          <= OCIOSO;
            botoes_q_reg       <= '0;
            confirma_q_reg     <= 1'b0;
            cancela_q_reg      <= 1'b0;
            pend_oh_reg        <= '0;
            cnt_reg            <= '0;
            escolhido_reg      <= '0;
            valido_reg         <= 1'b0;
            pend_idx_reg       <= '0;
            pendente_reg       <= 1'b0;
            erro_multiplo_reg  <= 1'b0;
            erro_eliminado_reg <= 1'b0;
            expirou_reg        <= 1'b0;
        end else begin
            botoes_q_reg       <= bus.botoes_jogadores;
            confirma_q_reg     <= bus.botao_confirma;
            cancela_q_reg      <= bus.botao_cancela;
            erro_multiplo_reg  <= 1'b0;
            erro_eliminado_reg <= 1'b0;
            expirou_reg        <= 1'b0;

            case (state_reg)
                OCIOSO: begin
                    if (bus.habilita) begin
                        state_reg <= AGUARDA;
                    end
                end

                AGUARDA: begin
                    if (!bus.habilita) begin
                        state_reg <= OCIOSO;
                    end else if (press_multi) begin
                        erro_multiplo_reg <= 1'b1;
                    end else if (press_unico) begin
                        if (!press_vivo) begin
                            erro_eliminado_reg <= 1'b1;
                        end else if (MODO_CONFIRMA) begin
                            state_reg    <= PENDENTE;
                            pend_oh_reg  <= press;
                            pend_idx_reg <= press_idx;
                            pendente_reg <= 1'b1;
                            cnt_reg      <= '0;
                        end else begin
                            state_reg     <= VALIDO;
                            escolhido_reg <= press_idx;
                            valido_reg    <= 1'b1;
                        end
                    end
                end

                PENDENTE: begin
                    if (!bus.habilita || !pend_vivo || cancela_ev || confirma_ev) begin
                        // Every exit from PENDENTE drops the highlighted player.
                        pend_oh_reg  <= '0;
                        pend_idx_reg <= '0;
                        pendente_reg <= 1'b0;
                        cnt_reg      <= '0;
                        if (!bus.habilita) begin
                            state_reg <= OCIOSO;
                        end else if (!pend_vivo) begin
                            state_reg          <= AGUARDA;
                            erro_eliminado_reg <= 1'b1;
                        end else if (cancela_ev) begin
                            state_reg <= AGUARDA;
                        end else begin
                            state_reg     <= VALIDO;
                            escolhido_reg <= pend_idx_reg;
                            valido_reg    <= 1'b1;
                        end
                    end else if (press_unico && press_vivo) begin
                        pend_oh_reg  <= press;
                        pend_idx_reg <= press_idx;
                        cnt_reg      <= '0;
                    end else begin
                        erro_multiplo_reg  <= press_multi;
                        erro_eliminado_reg <= press_unico && !press_vivo;
                        if (TIMEOUT_CICLOS > 0 && cnt_reg == CNT_MAX) begin
                            state_reg    <= AGUARDA;
                            expirou_reg  <= 1'b1;
                            pend_oh_reg  <= '0;
                            pend_idx_reg <= '0;
                            pendente_reg <= 1'b0;
                            cnt_reg      <= '0;
                        end else if (TIMEOUT_CICLOS > 0) begin
                            cnt_reg <= cnt_reg + W_CNT'(1);
                        end
                    end
                end

                VALIDO: begin
                    // The committed result stays up until consumed, even if
                    // the window closes meanwhile.
                    if (bus.ack) begin
                        valido_reg <= 1'b0;
                        state_reg  <= bus.habilita ? AGUARDA : OCIOSO;
                    end
                end

                default: state_reg <= OCIOSO;
            endcase
        end
    end

    assign bus.jogador_escolhido = escolhido_reg;
    assign bus.jogador_valido    = valido_reg;
    assign bus.jogador_pendente  = pend_idx_reg;
    assign bus.pendente          = pendente_reg;
    assign bus.erro_multiplo     = erro_multiplo_reg;
    assign bus.erro_eliminado    = erro_eliminado_reg;
    assign bus.expirou           = expirou_reg;
endmodule
